// File: rtl/alu_stage_pipe_pkg.sv
// Opcodes, IR field access and FSM encoding for the ALU execute stage.
// MUL is only implemented when ALU_MUL_EN is defined.
`define GET_OP(ir, msb) ir[(msb) -: 4]

package alu_stage_pipe_pkg;

   localparam int OPW = 4;

   localparam logic [OPW-1:0] ADD  = 4'h0;
   localparam logic [OPW-1:0] SUB  = 4'h1;
   localparam logic [OPW-1:0] SLT  = 4'h2;
   localparam logic [OPW-1:0] AND  = 4'h3;
   localparam logic [OPW-1:0] OR   = 4'h4;
   localparam logic [OPW-1:0] JUMP = 4'h5;
   localparam logic [OPW-1:0] ADDI = 4'h6;
   localparam logic [OPW-1:0] SW   = 4'h7;
   localparam logic [OPW-1:0] LW   = 4'h8;
   localparam logic [OPW-1:0] BEQ  = 4'h9;
   localparam logic [OPW-1:0] SLL  = 4'hA;
   localparam logic [OPW-1:0] SRL  = 4'hB;
   localparam logic [OPW-1:0] MUL  = 4'hC;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_stage_pipe_mul.sv
// Iterative shift-add multiplier, WIDTH/CYCLES multiplier bits per step.
// o_prod is the accumulator after the current step; final when o_done.
module alu_mul_iter #(
   parameter int WIDTH  = 16,
   parameter int CYCLES = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             i_start,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_prod
);

   localparam int STEP = WIDTH / CYCLES;
   localparam int CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_part;

   always_comb begin
      w_part = '0;
      for (int j = 0; j < STEP; j++) begin
         if (r_b[j]) w_part = w_part + (r_a << j);
      end
   end

   assign o_prod = r_acc + w_part;
   assign o_done = (r_cnt == CW'(CYCLES - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_en) begin
         r_acc <= o_prod;
         r_a   <= r_a << STEP;
         r_b   <= r_b >> STEP;
         if (!o_done) r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_stage_pipe.sv
// Valid/ready execute stage with one output register and optional
// iterative MUL (define ALU_MUL_EN); FLUSH overrides everything.
module alu_stage_pipe #(
   parameter int WIDTH      = 16,
   parameter int OP_MSB     = 15,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IRIN,
   input  logic [WIDTH-1:0] PCIN,
   input  logic [WIDTH-1:0] DATAIN1,
   input  logic [WIDTH-1:0] DATAIN2,
   input  logic [WIDTH-1:0] DATAIN3,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] PCOUT,
   output logic [WIDTH-1:0] IROUT,
   output logic [WIDTH-1:0] DATAOUT,
   output logic [WIDTH-1:0] ADDROUT,
   output logic             BUSY
);

   import alu_stage_pipe_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_valid;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_ir;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_addr;

   logic [OPW-1:0]   w_op;
   logic             w_free;
   logic             w_ready;
   logic             w_acc;
   logic             w_single;
   logic             w_is_mul;
   logic             w_mul_done;
   logic             w_mul_fire;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_adr;
   logic [WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_mpc;
   logic [WIDTH-1:0] w_mir;
   logic [WIDTH-1:0] w_maddr;

   assign w_op     = `GET_OP(IRIN, OP_MSB);
   assign w_free   = !r_valid || OUT_READY;
   assign w_ready  = RST_N && !FLUSH && (r_state == ST_IDLE) && w_free;
   assign w_acc    = IN_VALID && w_ready;
   assign IN_READY = w_ready;

   always_comb begin
      w_res    = '0;
      w_adr    = DATAIN1;
      w_single = 1'b1;
      case (w_op)
         ADD:  w_res = DATAIN2 + DATAIN3;
         SUB:  w_res = DATAIN2 - DATAIN3;
         AND:  w_res = DATAIN2 & DATAIN3;
         OR:   w_res = DATAIN2 | DATAIN3;
         SLT:  w_res = WIDTH'(DATAIN2 < DATAIN3);
         JUMP: w_res = DATAIN1;
         ADDI: w_res = DATAIN2;
         SW: begin
            w_res = DATAIN1;
            w_adr = DATAIN2;
         end
         LW:   w_res = DATAIN2;
         BEQ: begin
            w_adr = DATAIN3;
            w_res = (DATAIN1 == DATAIN2) ? '1 : '0;
         end
         SLL:  w_res = DATAIN2 << DATAIN3[SHW-1:0];
         SRL:  w_res = DATAIN2 >> DATAIN3[SHW-1:0];
         default: w_single = 1'b0;
      endcase
   end

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] r_mpc;
   logic [WIDTH-1:0] r_mir;
   logic [WIDTH-1:0] r_maddr;

   assign w_is_mul = (w_op == MUL);

   // PC/IR/address ride alongside the multiply until its result lands
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mpc   <= '0;
         r_mir   <= '0;
         r_maddr <= '0;
      end else if (w_acc && w_is_mul) begin
         r_mpc   <= PCIN;
         r_mir   <= IRIN;
         r_maddr <= DATAIN1;
      end
   end

   alu_mul_iter #(
      .WIDTH  (WIDTH),
      .CYCLES (MUL_CYCLES)
   ) u_mul (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_start (w_acc && w_is_mul),
      .i_en    (!(w_mul_done && !w_free)),
      .i_a     (DATAIN2),
      .i_b     (DATAIN3),
      .o_done  (w_mul_done),
      .o_prod  (w_prod)
   );

   assign w_mpc   = r_mpc;
   assign w_mir   = r_mir;
   assign w_maddr = r_maddr;
   assign BUSY    = (r_state == ST_MUL);
`else
   assign w_is_mul   = 1'b0;
   assign w_mul_done = 1'b0;
   assign w_prod     = '0;
   assign w_mpc      = '0;
   assign w_mir      = '0;
   assign w_maddr    = '0;
   assign BUSY       = 1'b0;
`endif

   assign w_mul_fire = (r_state == ST_MUL) && w_mul_done &&
                       w_free && !FLUSH;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (FLUSH) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_acc && w_is_mul) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_mul_done && w_free) w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_ir    <= '0;
         r_data  <= '0;
         r_addr  <= '0;
      end else if (FLUSH) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_ir    <= '0;
         r_data  <= '0;
         r_addr  <= '0;
      end else if (w_acc && w_single) begin
         r_valid <= 1'b1;
         r_pc    <= PCIN;
         r_ir    <= IRIN;
         r_data  <= w_res;
         r_addr  <= w_adr;
      end else if (w_mul_fire) begin
         r_valid <= 1'b1;
         r_pc    <= w_mpc;
         r_ir    <= w_mir;
         r_data  <= w_prod;
         r_addr  <= w_maddr;
      end else if (OUT_READY) begin
         // drained with nothing new (or a dropped opcode): a bubble
         r_valid <= 1'b0;
      end
   end

   assign OUT_VALID = r_valid;
   assign PCOUT     = r_pc;
   assign IROUT     = r_ir;
   assign DATAOUT   = r_data;
   assign ADDROUT   = r_addr;

endmodule

// File: tb/tb_alu_stage_pipe.sv
// Bench for alu_stage_pipe: vector table, directed corner sequences and
// a random stream against a queue-based reference model.
module tb_alu_stage_pipe;

   import alu_stage_pipe_pkg::*;

   logic        CLK;
   logic        RST_N;
   logic        FLUSH;
   logic        IN_VALID;
   logic        IN_READY;
   logic [15:0] IRIN;
   logic [15:0] PCIN;
   logic [15:0] DATAIN1;
   logic [15:0] DATAIN2;
   logic [15:0] DATAIN3;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] PCOUT;
   logic [15:0] IROUT;
   logic [15:0] DATAOUT;
   logic [15:0] ADDROUT;
   logic        BUSY;

   alu_stage_pipe u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .FLUSH     (FLUSH),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IRIN      (IRIN),
      .PCIN      (PCIN),
      .DATAIN1   (DATAIN1),
      .DATAIN2   (DATAIN2),
      .DATAIN3   (DATAIN3),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .PCOUT     (PCOUT),
      .IROUT     (IROUT),
      .DATAOUT   (DATAOUT),
      .ADDROUT   (ADDROUT),
      .BUSY      (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] d1, d2, d3, xd, xa;
   } vec_t;

   typedef struct packed {
      logic        known;
      logic [15:0] data;
      logic [15:0] addr;
   } mres_t;

   typedef struct {
      logic [15:0] pc, ir, data, addr;
   } exp_t;

   int   n_chk  = 0;
   int   n_pass = 0;
   vec_t tbl[15];
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drv(input logic [3:0] op, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3,
                      input logic [15:0] pc);
      IRIN    = {op, pc[11:0]};
      PCIN    = pc;
      DATAIN1 = d1;
      DATAIN2 = d2;
      DATAIN3 = d3;
   endtask

   function automatic mres_t model(input logic [3:0] op,
                                   input logic [15:0] d1,
                                   input logic [15:0] d2,
                                   input logic [15:0] d3);
      mres_t  r;
      longint a, b;
      a = longint'(d2);
      b = longint'(d3);
      r.known = 1'b1;
      r.data  = 16'h0;
      r.addr  = d1;
      case (op)
         ADD:  r.data = 16'((a + b) % 65536);
         SUB:  r.data = 16'((a - b + 65536) % 65536);
         AND:  r.data = d2 & d3;
         OR:   r.data = d2 | d3;
         SLT:  r.data = (a < b) ? 16'd1 : 16'd0;
         JUMP: r.data = d1;
         ADDI: r.data = d2;
         SW: begin
            r.data = d1;
            r.addr = d2;
         end
         LW:   r.data = d2;
         BEQ: begin
            r.addr = d3;
            r.data = (d1 == d2) ? 16'hFFFF : 16'h0000;
         end
         SLL:  r.data = 16'((a * (64'd1 << (b % 16))) % 65536);
         SRL:  r.data = 16'(a / (64'd1 << (b % 16)));
`ifdef ALU_MUL_EN
         MUL:  r.data = 16'((a * b) % 65536);
`endif
         default: r.known = 1'b0;
      endcase
      return r;
   endfunction

   task automatic sb_pop(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         chk({nm, "_extra"}, 32'(OUT_VALID), 32'd0);
      end else begin
         e = sb.pop_front();
         chk({nm, "_data"}, 32'(DATAOUT), 32'(e.data));
         chk({nm, "_addr"}, 32'(ADDROUT), 32'(e.addr));
         chk({nm, "_ir"},   32'(IROUT),   32'(e.ir));
         chk({nm, "_pc"},   32'(PCOUT),   32'(e.pc));
      end
   endtask

   initial begin
      int    k;
      mres_t m;
      exp_t  e;
      logic [3:0]  op;
      logic [15:0] a1, a2, a3, pc;

      tbl[0]  = '{ADD,  16'h0000, 16'h0003, 16'h0004, 16'h0007, 16'h0000};
      tbl[1]  = '{SUB,  16'h0000, 16'h0003, 16'h0004, 16'hFFFF, 16'h0000};
      tbl[2]  = '{SLT,  16'h0000, 16'h0003, 16'h0004, 16'h0001, 16'h0000};
      tbl[3]  = '{SLT,  16'h0000, 16'h0004, 16'h0003, 16'h0000, 16'h0000};
      tbl[4]  = '{AND,  16'h0000, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000};
      tbl[5]  = '{OR,   16'h0000, 16'hF0F0, 16'h0F00, 16'hFFF0, 16'h0000};
      tbl[6]  = '{JUMP, 16'h1111, 16'h0002, 16'h0003, 16'h1111, 16'h1111};
      tbl[7]  = '{ADDI, 16'h0005, 16'h2222, 16'h0000, 16'h2222, 16'h0005};
      tbl[8]  = '{SW,   16'hABCD, 16'h0100, 16'h0000, 16'hABCD, 16'h0100};
      tbl[9]  = '{LW,   16'h0200, 16'h5555, 16'h0000, 16'h5555, 16'h0200};
      tbl[10] = '{BEQ,  16'h1234, 16'h1234, 16'h0040, 16'hFFFF, 16'h0040};
      tbl[11] = '{BEQ,  16'h1234, 16'h1235, 16'h0040, 16'h0000, 16'h0040};
      tbl[12] = '{SLL,  16'h0000, 16'h0001, 16'h0013, 16'h0008, 16'h0000};
      tbl[13] = '{SRL,  16'h0000, 16'h8000, 16'h000F, 16'h0001, 16'h0000};
      tbl[14] = '{ADD,  16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000};

      RST_N = 1'b1;
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      drv(ADD, 0, 0, 0, 0);
      #2 RST_N = 1'b0;
      #1;
      chk("rst_in_ready", 32'(IN_READY), 32'd0);
      repeat (2) @(negedge CLK);
      chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_regs", {PCOUT | IROUT, DATAOUT | ADDROUT}, 32'd0);
      RST_N = 1'b1;
      #1 chk("idle_in_ready", 32'(IN_READY), 32'd1);

      // back-to-back table stream, one instruction per cycle
      @(negedge CLK);
      drv(tbl[0].op, tbl[0].d1, tbl[0].d2, tbl[0].d3, 16'h0100);
      IN_VALID = 1'b1;
      #1 chk("tbl_rdy0", 32'(IN_READY), 32'd1);
      for (int i = 1; i <= 15; i++) begin
         @(negedge CLK);
         chk($sformatf("tbl%0d_valid", i-1), 32'(OUT_VALID), 32'd1);
         chk($sformatf("tbl%0d_data", i-1), 32'(DATAOUT),
             32'(tbl[i-1].xd));
         chk($sformatf("tbl%0d_addr", i-1), 32'(ADDROUT),
             32'(tbl[i-1].xa));
         chk($sformatf("tbl%0d_pc", i-1), 32'(PCOUT),
             32'(16'h0100 + 16'(i-1)));
         if (i < 15) begin
            drv(tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].d3,
                16'h0100 + 16'(i));
            #1 chk($sformatf("tbl_rdy%0d", i), 32'(IN_READY), 32'd1);
         end else begin
            IN_VALID = 1'b0;
         end
      end
      @(negedge CLK);
      chk("tbl_bubble", 32'(OUT_VALID), 32'd0);

      // back-pressure: ADD 5+5 held for 3 cycles, then ADD 1+1 follows
      drv(ADD, 0, 5, 5, 16'h0200);
      IN_VALID = 1'b1;
      @(negedge CLK);
      drv(ADD, 0, 1, 1, 16'h0201);
      OUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid", 32'(OUT_VALID), 32'd1);
         chk("bp_data", 32'(DATAOUT), 32'h000A);
         chk("bp_pc", 32'(PCOUT), 32'h0200);
         chk("bp_ready", 32'(IN_READY), 32'd0);
         @(negedge CLK);
      end
      OUT_READY = 1'b1;
      #1 chk("bp_release_rdy", 32'(IN_READY), 32'd1);
      @(negedge CLK);
      IN_VALID = 1'b0;
      chk("bp_next_data", 32'(DATAOUT), 32'h0002);
      chk("bp_next_pc", 32'(PCOUT), 32'h0201);
      @(negedge CLK);
      chk("bp_no_dup", 32'(OUT_VALID), 32'd0);

      // MUL 300*300
      drv(MUL, 0, 16'd300, 16'd300, 16'h0300);
      IN_VALID = 1'b1;
      #1 chk("mul_accept", 32'(IN_READY), 32'd1);
      @(negedge CLK);
      IN_VALID = 1'b0;
`ifdef ALU_MUL_EN
      k = 0;
      for (int i = 0; i < 40; i++) begin
         if (!BUSY) break;
         if (IN_READY) chk("mul_busy_rdy", 32'(IN_READY), 32'd0);
         k++;
         @(negedge CLK);
      end
      chk("mul_busy_cycles", 32'(k), 32'd16);
      chk("mul_valid", 32'(OUT_VALID), 32'd1);
      chk("mul_data", 32'(DATAOUT), 32'h5F90);
      chk("mul_pc", 32'(PCOUT), 32'h0300);
`else
      k = 0;
      for (int i = 0; i < 20; i++) begin
         if (OUT_VALID || BUSY) k++;
         @(negedge CLK);
      end
      chk("mul_dropped", 32'(k), 32'd0);
`endif
      @(negedge CLK);

      // FLUSH with a held output
      drv(ADD, 0, 9, 9, 16'h0400);
      IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      chk("fl_held_data", 32'(DATAOUT), 32'h0012);
      @(negedge CLK);
      FLUSH = 1'b1;
      drv(ADD, 0, 7, 7, 16'h0401);
      IN_VALID = 1'b1;
      #1 chk("fl_in_ready", 32'(IN_READY), 32'd0);
      @(negedge CLK);
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      chk("fl_valid", 32'(OUT_VALID), 32'd0);
      chk("fl_regs", {PCOUT | IROUT, DATAOUT | ADDROUT}, 32'd0);
      drv(ADD, 0, 1, 2, 16'h0402);
      IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      chk("fl_after_data", 32'(DATAOUT), 32'h0003);
      chk("fl_after_valid", 32'(OUT_VALID), 32'd1);

      // FLUSH at MUL iteration 5
      drv(MUL, 0, 16'd300, 16'd300, 16'h0500);
      IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      repeat (4) @(negedge CLK);
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
      chk("flm_busy", 32'(BUSY), 32'd0);
      chk("flm_valid", 32'(OUT_VALID), 32'd0);
      chk("flm_data", 32'(DATAOUT), 32'd0);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (OUT_VALID || BUSY) k++;
      end
      chk("flm_quiet", 32'(k), 32'd0);
      drv(ADD, 0, 16'h1000, 16'h0234, 16'h0501);
      IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      chk("flm_add", 32'(DATAOUT), 32'h1234);

      // asynchronous reset mid-MUL
      drv(MUL, 0, 16'd300, 16'd300, 16'h0600);
      IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      repeat (4) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      chk("rm_busy", 32'(BUSY), 32'd0);
      chk("rm_valid", 32'(OUT_VALID), 32'd0);
      chk("rm_regs", {PCOUT | IROUT, DATAOUT | ADDROUT}, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (OUT_VALID || BUSY) k++;
      end
      chk("rm_quiet", 32'(k), 32'd0);

      // random stream with random back-pressure
      for (int c = 0; c < 600; c++) begin
         @(negedge CLK);
         op = 4'($urandom_range(15));
         a1 = 16'($urandom);
         a2 = 16'($urandom);
         a3 = 16'($urandom);
         pc = 16'(c);
         drv(op, a1, a2, a3, pc);
         IN_VALID  = ($urandom_range(3) != 0);
         OUT_READY = ($urandom_range(3) != 0);
         #1;
         if (OUT_VALID && OUT_READY) sb_pop("rnd");
         if (IN_VALID && IN_READY) begin
            m = model(op, a1, a2, a3);
            if (m.known) begin
               e.pc   = pc;
               e.ir   = IRIN;
               e.data = m.data;
               e.addr = m.addr;
               sb.push_back(e);
            end
         end
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         #1;
         if (OUT_VALID) sb_pop("drain");
         else if (sb.size() == 0) break;
      end
      chk("rnd_drain_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_stage_pipe.md
Name: alu_stage_pipe

Overview:
- Parametrised execute stage of the pipelined CPU, sitting between the register-read stage and the memory/writeback stage.
- Replaces the fixed 16-bit stage with enable flags by a valid/ready pipeline stage of configurable width.
- Holds one skid register, so back-pressure from memory never drops an instruction.
- Adds shift ops, a multi-cycle iterative multiply, flush, and a full-width SLT result.

Parameters:
- WIDTH, 16: datapath width of IR, PC, data and address buses.
- OP_MSB, 15: top bit of the opcode field within the IR.
- MUL_CYCLES, WIDTH: iterations of the shift-add multiplier. Legal range 1..WIDTH; must divide WIDTH.

Ports:
- CLK  in  1  rising-edge clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous kill of the in-flight and held instruction.
- IN_VALID  in  1  upstream instruction present.
- IN_READY  out  1  stage accepts this cycle.
- IRIN  in  WIDTH  instruction; opcode = IRIN[OP_MSB:OP_MSB-3].
- PCIN  in  WIDTH  instruction PC.
- DATAIN1  in  WIDTH  operand 1 (rs / store data / jump target).
- DATAIN2  in  WIDTH  operand 2.
- DATAIN3  in  WIDTH  operand 3 (rt / branch target).
- OUT_VALID  out  1  result register holds a valid instruction.
- OUT_READY  in  1  downstream accepts.
- PCOUT  out  WIDTH  registered PC.
- IROUT  out  WIDTH  registered IR.
- DATAOUT  out  WIDTH  result.
- ADDROUT  out  WIDTH  memory/branch address.
- BUSY  out  1  multiplier iterating.

Behaviour:
- Reset (RST_N low, asynchronous): OUT_VALID=0, BUSY=0, state=IDLE, and PCOUT/IROUT/DATAOUT/ADDROUT all zero. IN_READY=0 while reset is asserted.
- Transfer rules:
  - Input transfer occurs when IN_VALID && IN_READY.
  - Output transfer occurs when OUT_VALID && OUT_READY.
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
- Single-cycle ops are registered at the accepting edge, giving OUT_VALID on the next cycle. A full-throughput stream runs at 1 instruction/cycle.
- Opcode results (default ADDROUT=DATAIN1, PCOUT=PCIN, IROUT=IRIN):
  - ADD: D2+D3.
  - SUB: D2-D3.
  - AND: D2&D3.
  - OR: D2|D3.
  - SLT: unsigned D2<D3 gives 1, else 0, zero-extended to the full WIDTH.
  - JUMP: D1.
  - ADDI: D2.
  - SW: DATAOUT=D1, ADDROUT=D2.
  - LW: ADDROUT=D1, DATAOUT=D2.
  - BEQ: ADDROUT=D3; DATAOUT=all-ones if D1==D2, else 0.
  - SLL: D2<<D3[log2(WIDTH)-1:0].
  - SRL: D2>>D3[log2(WIDTH)-1:0], logical.
- Arithmetic wraps modulo 2^WIDTH; carries are discarded.
- Unknown opcode is accepted and dropped: no OUT_VALID and the output registers are unchanged, so it acts as a bubble.
- FSM, states IDLE and MUL:
  - IDLE→MUL on accepting MUL (feature enabled). BUSY=1 in MUL.
  - MUL holds the operands and partial product, processing WIDTH/MUL_CYCLES bits per cycle.
  - MUL→IDLE after MUL_CYCLES cycles, loading the low WIDTH bits of D2*D3 into DATAOUT with OUT_VALID=1. Latency is MUL_CYCLES+1 from acceptance.
  - The MUL result is not written while OUT_VALID && !OUT_READY; the FSM stalls in its final cycle until the output is free.
- Output stability: while OUT_VALID && !OUT_READY, all outputs hold.
- Simultaneous output drain and input accept in the same cycle: the new result replaces the old one, and OUT_VALID stays 1.
- FLUSH has priority over all other events. It clears OUT_VALID, aborts MUL (state→IDLE, BUSY=0), forces IN_READY=0 that cycle, and does not accept IN. Output data registers are zeroed.
- Reset mid-MUL: the partial product is discarded and no result is emitted.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL opcode is implemented with the FSM, BUSY and latency described above.
- Undefined: MUL decodes as an unknown opcode (dropped). The MUL state and multiplier logic are absent, and BUSY is tied 0.

Decomposition:
- Shared package/header (the existing cpu defines file):
  - opcode constants ADD, SUB, SLT, AND, OR, JUMP, ADDI, SW, LW, BEQ, plus new SLL, SRL, MUL;
  - the GET_OP field macro;
  - the FSM state encoding for IDLE and MUL.
- One sub-module, alu_mul_iter: a WIDTH-parametrised iterative shift-add multiplier with start/done ports, instantiated only under ALU_MUL_EN.

Test Plan:
- Reset then back-to-back stream with OUT_READY=1: ADD 3+4, SUB 3-4, SLT 3<4. Next-cycle DATAOUT sequence 7, FFFF, 0001; IN_READY held 1 throughout.
- Back-pressure: OUT_READY=0 for 3 cycles after ADD 5+5. DATAOUT holds 000A with OUT_VALID=1, IN_READY=0; on release, the next instruction follows with no loss or duplication.
- BEQ D1=D2=0x1234, D3=0x0040 gives ADDROUT=0040, DATAOUT=FFFF. With D2=0x1235, DATAOUT=0000.
- SLL D2=0x0001, D3=0x0013 gives 0x0008 (shift amount masked to 3). SRL D2=0x8000, D3=15 gives 0x0001.
- MUL (ALU_MUL_EN, WIDTH=16, MUL_CYCLES=16) with D2=300, D3=300:
  - BUSY=1 for 16 cycles, IN_READY=0;
  - DATAOUT=0x5F90 (90000 mod 2^16) at cycle 17 after acceptance.
  - Without the macro, the same MUL yields no OUT_VALID.
- FLUSH asserted at MUL iteration 5 and again with a held output: OUT_VALID=0, BUSY=0, outputs zero, and the next ADD completes normally. RST_N pulsed low mid-MUL clears everything asynchronously.
